// File: rtl/prog_sequencer_if.sv
// Handshake/bus bundle between the controller and prog_sequencer.
// The master side drives the controls and the sequencer (slave side) reports its state.
interface prog_sequencer_if #(
    parameter int ADDR_W = 6,
    parameter int INST_W = 23,
    parameter int DATA_W = 16
);
    logic              start;
    logic              write;
    logic [INST_W-1:0] program_in;
    logic              inc_pc;
    logic              branch;
    logic [DATA_W-1:0] bus;
    logic              halt_req;
    logic              call;
    logic              ret;

    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              inst_valid;
    logic              running;
    logic              done;
    logic [ADDR_W:0]   prog_len;
    logic              load_full;
    logic              stack_err;

    modport master (
        output start, write, program_in, inc_pc, branch, bus, halt_req, call, ret,
        input  pc, inst, inst_valid, running, done, prog_len, load_full, stack_err
    );

    modport slave (
        input  start, write, program_in, inc_pc, branch, bus, halt_req, call, ret,
        output pc, inst, inst_valid, running, done, prog_len, load_full, stack_err
    );
endinterface

// File: rtl/prog_sequencer.sv
// Program store plus program counter with LOAD/RUN/HALT control and done reporting.
// Define SEQ_CALL_STACK_EN to build the call/return stack; otherwise call acts as branch.
module prog_sequencer #(
    parameter int ADDR_W  = 6,
    parameter int DEPTH   = 64,
    parameter int INST_W  = 23,
    parameter int DATA_W  = 16,
    parameter int STACK_D = 4
) (
    input  logic clk,
    input  logic rst_n,
    prog_sequencer_if.slave seq_if
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_e;

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [LEN_W-1:0] a);
        return ADDR_W'(a % DEPTH_L);
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q;
    logic              inst_valid_q, inst_valid_d;
    logic              done_q, done_d;
    logic [LEN_W-1:0]  prog_len_q, prog_len_d;
    logic              load_full_q, load_full_d;
    logic              enter_run;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [INST_W-1:0] mem [DEPTH];

    logic [LEN_W-1:0]  pc_inc;
    logic [ADDR_W-1:0] bus_tgt;

    assign pc_inc  = {1'b0, pc_q} + LEN_W'(1);
    assign bus_tgt = wrap_addr({1'b0, seq_if.bus[ADDR_W-1:0]});

`ifdef SEQ_CALL_STACK_EN
    localparam int SP_W = $clog2(STACK_D + 1);
    localparam int SI_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

    logic [SP_W-1:0]   sp_q, sp_d;
    logic              stack_err_q, stack_err_d;
    logic              push;
    logic [ADDR_W-1:0] stack_q [STACK_D];
    logic [ADDR_W-1:0] stack_top;

    assign stack_top = stack_q[SI_W'(sp_q - SP_W'(1))];
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        done_d      = done_q;
        prog_len_d  = prog_len_q;
        load_full_d = load_full_q;
        mem_we      = 1'b0;
        mem_waddr   = prog_len_q[ADDR_W-1:0];
        enter_run   = 1'b0;
`ifdef SEQ_CALL_STACK_EN
        sp_d        = sp_q;
        stack_err_d = stack_err_q;
        push        = 1'b0;
`endif
        case (state_q)
            IDLE, HALT: begin
                if (seq_if.start) begin
                    enter_run = 1'b1;
                end else if (seq_if.write) begin
                    state_d    = LOAD;
                    prog_len_d = LEN_W'(1);
                    mem_we     = 1'b1;
                    mem_waddr  = '0;
                end
            end
            LOAD: begin
                if (seq_if.start) begin
                    enter_run = 1'b1;
                end else if (seq_if.write) begin
                    if (prog_len_q == DEPTH_L) begin
                        load_full_d = 1'b1;
                    end else begin
                        mem_we     = 1'b1;
                        prog_len_d = prog_len_q + LEN_W'(1);
                    end
                end
            end
            RUN: begin
                // halt_req pre-empts every pc update; an empty program ends immediately
                if (seq_if.halt_req) begin
                    state_d = HALT;
                end else if (prog_len_q == '0) begin
                    state_d = HALT;
                    done_d  = 1'b1;
                end
`ifdef SEQ_CALL_STACK_EN
                else if (seq_if.call) begin
                    pc_d = bus_tgt;
                    if (sp_q == SP_W'(STACK_D)) begin
                        stack_err_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + SP_W'(1);
                    end
                end else if (seq_if.ret) begin
                    if (sp_q == '0) begin
                        stack_err_d = 1'b1;
                    end else begin
                        pc_d = stack_top;
                        sp_d = sp_q - SP_W'(1);
                    end
                end else if (seq_if.branch) begin
                    pc_d = bus_tgt;
                end
`else
                else if (seq_if.branch || seq_if.call) begin
                    pc_d = bus_tgt;
                end
`endif
                else if (seq_if.inc_pc) begin
                    if (pc_inc == prog_len_q) begin
                        state_d = HALT;
                        done_d  = 1'b1;
                    end else begin
                        pc_d = wrap_addr(pc_inc);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_run) begin
            state_d = RUN;
            pc_d    = '0;
            done_d  = 1'b0;
`ifdef SEQ_CALL_STACK_EN
            sp_d    = '0;
`endif
        end

        // inst lags pc by one edge, so it only matches when pc holds still
        inst_valid_d = (state_q == RUN) && (state_d == RUN) && (pc_d == pc_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            done_q       <= 1'b0;
            prog_len_q   <= '0;
            load_full_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            done_q       <= done_d;
            prog_len_q   <= prog_len_d;
            load_full_q  <= load_full_d;
            if (state_q == RUN) begin
                inst_q <= mem[pc_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_waddr] <= seq_if.program_in;
        end
    end

`ifdef SEQ_CALL_STACK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q        <= '0;
            stack_err_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            stack_err_q <= stack_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            stack_q[SI_W'(sp_q)] <= wrap_addr(pc_inc);
        end
    end

    assign seq_if.stack_err = stack_err_q;
`else
    logic unused_nostack;
    assign unused_nostack   = seq_if.ret ^ (STACK_D > 0);
    assign seq_if.stack_err = 1'b0;
`endif

    generate
        if (DATA_W > ADDR_W) begin : g_bus_hi
            logic unused_bus_hi;
            assign unused_bus_hi = ^seq_if.bus[DATA_W-1:ADDR_W];
        end
    endgenerate

    assign seq_if.pc         = pc_q;
    assign seq_if.inst       = inst_q;
    assign seq_if.inst_valid = inst_valid_q;
    assign seq_if.running    = (state_q == RUN);
    assign seq_if.done       = done_q;
    assign seq_if.prog_len   = prog_len_q;
    assign seq_if.load_full  = load_full_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: load, run, branch, halt, reset, overflow and call/return.
// Build with SEQ_CALL_STACK_EN defined to exercise the return stack (STACK_D=2).
module tb_prog_sequencer;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int INST_W = 23;
    localparam int DATA_W = 16;
`ifdef SEQ_CALL_STACK_EN
    localparam int STACK_D = 2;
`else
    localparam int STACK_D = 4;
`endif

    localparam logic [INST_W-1:0] BASE_A = 23'h0A0000;
    localparam logic [INST_W-1:0] BASE_F = 23'h300000;
    localparam logic [INST_W-1:0] BASE_C = 23'h050000;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    prog_sequencer_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DATA_W(DATA_W)) sif ();

    prog_sequencer #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .INST_W(INST_W), .DATA_W(DATA_W), .STACK_D(STACK_D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .seq_if(sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input int n, input logic [INST_W-1:0] base);
        for (int i = 0; i < n; i++) begin
            sif.write      = 1'b1;
            sif.program_in = base + INST_W'(i);
            tick();
        end
        sif.write = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (sif.pc !== 6'd0) begin errors++; $display("[TB] FAIL reset_pc: got %0d expected 0", sif.pc); end
        checks++; if (sif.inst !== 23'd0) begin errors++; $display("[TB] FAIL reset_inst: got %h expected 0", sif.inst); end
        checks++; if (sif.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", sif.inst_valid); end
        checks++; if (sif.running !== 1'b0) begin errors++; $display("[TB] FAIL reset_running: got %b expected 0", sif.running); end
        checks++; if (sif.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", sif.done); end
        checks++; if (sif.prog_len !== 7'd0) begin errors++; $display("[TB] FAIL reset_len: got %0d expected 0", sif.prog_len); end
        checks++; if (sif.load_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", sif.load_full); end
        checks++; if (sif.stack_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_stack_err: got %b expected 0", sif.stack_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_run_basic();
        load_prog(5, BASE_A);
        checks++; if (sif.prog_len !== 7'd5) begin errors++; $display("[TB] FAIL load_len: got %0d expected 5", sif.prog_len); end
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        checks++; if (sif.running !== 1'b1) begin errors++; $display("[TB] FAIL run_entry_running: got %b expected 1", sif.running); end
        checks++; if (sif.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL run_entry_valid: got %b expected 0", sif.inst_valid); end
        tick();
        checks++; if (sif.inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL run_second_valid: got %b expected 1", sif.inst_valid); end
        checks++; if (sif.inst !== BASE_A) begin errors++; $display("[TB] FAIL run_second_inst: got %h expected %h", sif.inst, BASE_A); end
        sif.inc_pc = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (sif.pc !== 6'(i)) begin errors++; $display("[TB] FAIL run_pc[%0d]: got %0d expected %0d", i, sif.pc, i); end
            checks++; if (sif.inst !== BASE_A + INST_W'(i - 1)) begin errors++; $display("[TB] FAIL run_inst[%0d]: got %h expected %h", i, sif.inst, BASE_A + INST_W'(i - 1)); end
        end
        tick();
        sif.inc_pc = 1'b0;
        checks++; if (sif.running !== 1'b0) begin errors++; $display("[TB] FAIL end_running: got %b expected 0", sif.running); end
        checks++; if (sif.done !== 1'b1) begin errors++; $display("[TB] FAIL end_done: got %b expected 1", sif.done); end
        checks++; if (sif.pc !== 6'd4) begin errors++; $display("[TB] FAIL end_pc: got %0d expected 4", sif.pc); end
        checks++; if (sif.inst !== BASE_A + 23'd4) begin errors++; $display("[TB] FAIL end_inst: got %h expected %h", sif.inst, BASE_A + 23'd4); end
        checks++; if (sif.prog_len !== 7'd5) begin errors++; $display("[TB] FAIL end_len: got %0d expected 5", sif.prog_len); end
    endtask

    task automatic test_branch();
        sif.start = 1'b1;
        tick();
        sif.start  = 1'b0;
        sif.inc_pc = 1'b1;
        tick();
        tick();
        sif.inc_pc = 1'b0;
        sif.branch = 1'b1;
        sif.bus    = 16'h0041;
        tick();
        sif.branch = 1'b0;
        checks++; if (sif.pc !== 6'd1) begin errors++; $display("[TB] FAIL branch_pc: got %0d expected 1", sif.pc); end
        checks++; if (sif.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL branch_bubble: got %b expected 0", sif.inst_valid); end
        tick();
        checks++; if (sif.inst !== BASE_A + 23'd1) begin errors++; $display("[TB] FAIL branch_inst: got %h expected %h", sif.inst, BASE_A + 23'd1); end
        checks++; if (sif.inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL branch_valid: got %b expected 1", sif.inst_valid); end
    endtask

    task automatic test_halt_priority();
        sif.inc_pc = 1'b1;
        tick();
        tick();
        checks++; if (sif.pc !== 6'd3) begin errors++; $display("[TB] FAIL halt_setup_pc: got %0d expected 3", sif.pc); end
        sif.halt_req = 1'b1;
        sif.branch   = 1'b1;
        sif.bus      = 16'h0005;
        tick();
        sif.halt_req = 1'b0;
        sif.branch   = 1'b0;
        sif.inc_pc   = 1'b0;
        checks++; if (sif.running !== 1'b0) begin errors++; $display("[TB] FAIL halt_running: got %b expected 0", sif.running); end
        checks++; if (sif.pc !== 6'd3) begin errors++; $display("[TB] FAIL halt_pc: got %0d expected 3", sif.pc); end
        checks++; if (sif.done !== 1'b0) begin errors++; $display("[TB] FAIL halt_done: got %b expected 0", sif.done); end
        tick();
        checks++; if (sif.pc !== 6'd3) begin errors++; $display("[TB] FAIL halt_hold_pc: got %0d expected 3", sif.pc); end
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        checks++; if (sif.pc !== 6'd0) begin errors++; $display("[TB] FAIL restart_pc: got %0d expected 0", sif.pc); end
        checks++; if (sif.running !== 1'b1) begin errors++; $display("[TB] FAIL restart_running: got %b expected 1", sif.running); end
    endtask

    task automatic test_reset_mid_run();
        sif.inc_pc = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (sif.pc !== 6'd4) begin errors++; $display("[TB] FAIL midrun_pc: got %0d expected 4", sif.pc); end
        rst_n = 1'b0;
        tick();
        rst_n      = 1'b1;
        sif.inc_pc = 1'b0;
        checks++; if (sif.pc !== 6'd0) begin errors++; $display("[TB] FAIL midrun_reset_pc: got %0d expected 0", sif.pc); end
        checks++; if (sif.running !== 1'b0) begin errors++; $display("[TB] FAIL midrun_reset_running: got %b expected 0", sif.running); end
        checks++; if (sif.inst !== 23'd0) begin errors++; $display("[TB] FAIL midrun_reset_inst: got %h expected 0", sif.inst); end
        checks++; if (sif.prog_len !== 7'd0) begin errors++; $display("[TB] FAIL midrun_reset_len: got %0d expected 0", sif.prog_len); end
    endtask

    task automatic test_empty_program();
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        checks++; if (sif.running !== 1'b1) begin errors++; $display("[TB] FAIL empty_running: got %b expected 1", sif.running); end
        checks++; if (sif.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL empty_valid0: got %b expected 0", sif.inst_valid); end
        tick();
        checks++; if (sif.running !== 1'b0) begin errors++; $display("[TB] FAIL empty_halt: got %b expected 0", sif.running); end
        checks++; if (sif.done !== 1'b1) begin errors++; $display("[TB] FAIL empty_done: got %b expected 1", sif.done); end
        checks++; if (sif.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL empty_valid1: got %b expected 0", sif.inst_valid); end
    endtask

    task automatic test_load_full();
        load_prog(65, BASE_F);
        checks++; if (sif.prog_len !== 7'd64) begin errors++; $display("[TB] FAIL full_len: got %0d expected 64", sif.prog_len); end
        checks++; if (sif.load_full !== 1'b1) begin errors++; $display("[TB] FAIL full_flag: got %b expected 1", sif.load_full); end
        sif.start = 1'b1;
        tick();
        sif.start  = 1'b0;
        sif.inc_pc = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            tick();
            checks++; if (sif.inst !== BASE_F + INST_W'(i - 1)) begin errors++; $display("[TB] FAIL full_inst[%0d]: got %h expected %h", i - 1, sif.inst, BASE_F + INST_W'(i - 1)); end
        end
        tick();
        sif.inc_pc = 1'b0;
        checks++; if (sif.inst !== BASE_F + 23'd63) begin errors++; $display("[TB] FAIL full_last_inst: got %h expected %h", sif.inst, BASE_F + 23'd63); end
        checks++; if (sif.done !== 1'b1) begin errors++; $display("[TB] FAIL full_done: got %b expected 1", sif.done); end
        checks++; if (sif.pc !== 6'd63) begin errors++; $display("[TB] FAIL full_pc: got %0d expected 63", sif.pc); end
    endtask

    task automatic test_start_write_same_cycle();
        do_reset();
        sif.start      = 1'b1;
        sif.write      = 1'b1;
        sif.program_in = 23'h7FFFFF;
        tick();
        sif.start = 1'b0;
        sif.write = 1'b0;
        checks++; if (sif.running !== 1'b1) begin errors++; $display("[TB] FAIL sw_running: got %b expected 1", sif.running); end
        checks++; if (sif.prog_len !== 7'd0) begin errors++; $display("[TB] FAIL sw_len: got %0d expected 0", sif.prog_len); end
        checks++; if (sif.load_full !== 1'b0) begin errors++; $display("[TB] FAIL sw_full: got %b expected 0", sif.load_full); end
        tick();
        checks++; if (sif.inst !== BASE_F) begin errors++; $display("[TB] FAIL sw_mem0: got %h expected %h", sif.inst, BASE_F); end
        checks++; if (sif.done !== 1'b1) begin errors++; $display("[TB] FAIL sw_done: got %b expected 1", sif.done); end
    endtask

    task automatic test_call();
        do_reset();
        load_prog(30, BASE_C);
        sif.start = 1'b1;
        tick();
        sif.start  = 1'b0;
        sif.inc_pc = 1'b1;
        tick();
        sif.inc_pc = 1'b0;
        checks++; if (sif.pc !== 6'd1) begin errors++; $display("[TB] FAIL call_setup_pc: got %0d expected 1", sif.pc); end
`ifdef SEQ_CALL_STACK_EN
        sif.call = 1'b1;
        sif.bus  = 16'd10;
        tick();
        checks++; if (sif.pc !== 6'd10) begin errors++; $display("[TB] FAIL call1_pc: got %0d expected 10", sif.pc); end
        sif.bus = 16'd20;
        tick();
        checks++; if (sif.pc !== 6'd20) begin errors++; $display("[TB] FAIL call2_pc: got %0d expected 20", sif.pc); end
        checks++; if (sif.stack_err !== 1'b0) begin errors++; $display("[TB] FAIL call2_err: got %b expected 0", sif.stack_err); end
        sif.bus = 16'd5;
        tick();
        checks++; if (sif.pc !== 6'd5) begin errors++; $display("[TB] FAIL call3_pc: got %0d expected 5", sif.pc); end
        checks++; if (sif.stack_err !== 1'b1) begin errors++; $display("[TB] FAIL call3_err: got %b expected 1", sif.stack_err); end
        sif.call = 1'b0;
        sif.ret  = 1'b1;
        tick();
        checks++; if (sif.pc !== 6'd11) begin errors++; $display("[TB] FAIL ret1_pc: got %0d expected 11", sif.pc); end
        tick();
        checks++; if (sif.pc !== 6'd2) begin errors++; $display("[TB] FAIL ret2_pc: got %0d expected 2", sif.pc); end
        tick();
        sif.ret = 1'b0;
        checks++; if (sif.pc !== 6'd2) begin errors++; $display("[TB] FAIL ret3_pc: got %0d expected 2", sif.pc); end
        checks++; if (sif.stack_err !== 1'b1) begin errors++; $display("[TB] FAIL ret3_err: got %b expected 1", sif.stack_err); end
`else
        sif.call = 1'b1;
        sif.bus  = 16'h004A;
        tick();
        sif.call = 1'b0;
        checks++; if (sif.pc !== 6'd10) begin errors++; $display("[TB] FAIL callbr_pc: got %0d expected 10", sif.pc); end
        sif.ret = 1'b1;
        tick();
        sif.ret = 1'b0;
        checks++; if (sif.pc !== 6'd10) begin errors++; $display("[TB] FAIL retign_pc: got %0d expected 10", sif.pc); end
        checks++; if (sif.stack_err !== 1'b0) begin errors++; $display("[TB] FAIL retign_err: got %b expected 0", sif.stack_err); end
`endif
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst_n          = 1'b0;
        sif.start      = 1'b0;
        sif.write      = 1'b0;
        sif.program_in = '0;
        sif.inc_pc     = 1'b0;
        sif.branch     = 1'b0;
        sif.bus        = '0;
        sif.halt_req   = 1'b0;
        sif.call       = 1'b0;
        sif.ret        = 1'b0;
        $display("[TB] prog_sequencer directed test start");
        test_reset();
        test_run_basic();
        test_branch();
        test_halt_priority();
        test_reset_mid_run();
        test_empty_program();
        test_load_full();
        test_start_write_same_cycle();
        test_call();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
